// File: rtl/accel_sequencer.sv
// Accelerometer sequencer: configures the sensor through the shared SPIMaster, then issues
// timer/INT1-driven 7-byte burst reads from STATUS_REG and unpacks signed X/Y/Z samples.
module accel_sequencer #(
  parameter int unsigned POLL_DIV      = 1048576,
  parameter logic [7:0]  CTRL_REG1_VAL = 8'h2F,
  parameter logic [7:0]  CTRL_REG4_VAL = 8'h00,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter bit          USE_INT       = 1'b1
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        int1,
  input  logic        spi_ready,
  input  logic [55:0] spi_rdata,
  input  logic        overrun_clr,
  output logic        spi_enable,
  output logic        spi_rw,
  output logic [5:0]  spi_address,
  output logic [7:0]  spi_wdata,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        configured,
  output logic        overrun,
  output logic        err_timeout,
  output logic [2:0]  dbg_state
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_CFG1 = 3'd1,
    ST_CFG2 = 3'd2,
    ST_WAIT = 3'd3,
    ST_READ = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_spi_enable;
  logic           r_spi_rw;
  logic [5:0]     r_spi_address;
  logic [7:0]     r_spi_wdata;
  logic [15:0]    r_sample_x;
  logic [15:0]    r_sample_y;
  logic [15:0]    r_sample_z;
  logic           r_sample_valid;
  logic           r_configured;
  logic           r_overrun;
  logic           r_err_timeout;
  logic [PW-1:0]  r_poll_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic           r_pending;
  logic           r_int1_meta;
  logic           r_int1_sync;
  logic           r_int1_prev;

  logic           w_busy;
  logic           w_done;
  logic           w_timeout;
  logic           w_tick;
  logic           w_int_rise;
  logic           w_trig;
  logic           w_en_next;
  logic           w_rw_next;
  logic [5:0]     w_addr_next;
  logic [7:0]     w_wdata_next;
  logic           w_accept;
  logic           w_unused;

  // Handshake: spi_enable is the request and stays high until a 1-cycle spi_ready is
  // sampled (transaction complete) or the timeout expires; ready with enable low is ignored.
  assign w_busy     = (r_state == ST_CFG1) || (r_state == ST_CFG2) || (r_state == ST_READ);
  assign w_done     = w_busy && r_spi_enable && spi_ready;
  assign w_timeout  = w_busy && r_spi_enable && !spi_ready && (r_to_cnt == TO_LAST);
  assign w_tick     = (r_poll_cnt == POLL_LAST);
  assign w_int_rise = r_int1_sync && !r_int1_prev;
  assign w_trig     = w_tick || (USE_INT && w_int_rise);
  assign w_accept   = w_done && (r_state == ST_READ) && spi_rdata[51];
  assign w_unused   = ^{spi_rdata[54:52], spi_rdata[50:48]};

  always_comb begin
    w_next       = r_state;
    w_en_next    = 1'b0;
    w_rw_next    = 1'b0;
    w_addr_next  = 6'h00;
    w_wdata_next = 8'h00;
    case (r_state)
      ST_RST:  w_next = ST_CFG1;
      ST_CFG1: if (w_done) w_next = ST_CFG2;
      ST_CFG2: if (w_done) w_next = ST_WAIT;
      ST_WAIT: if (w_trig || r_pending) w_next = ST_READ;
      ST_READ: if (w_done) w_next = ST_WAIT;
      default: w_next = ST_RST;
    endcase
    if (w_timeout) w_next = ST_CFG1;
    // Outputs follow the state being entered; a timeout forces one idle cycle before retrying.
    case (w_next)
      ST_CFG1: begin
        w_en_next    = !w_timeout;
        w_addr_next  = 6'h20;
        w_wdata_next = CTRL_REG1_VAL;
      end
      ST_CFG2: begin
        w_en_next    = 1'b1;
        w_addr_next  = 6'h23;
        w_wdata_next = CTRL_REG4_VAL;
      end
      ST_READ: begin
        w_en_next   = 1'b1;
        w_rw_next   = 1'b1;
        w_addr_next = 6'h27;
      end
      default: begin
        w_en_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RST;
    else          r_state <= w_next;
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_spi_enable   <= 1'b0;
      r_spi_rw       <= 1'b0;
      r_spi_address  <= 6'h00;
      r_spi_wdata    <= 8'h00;
      r_sample_x     <= 16'h0000;
      r_sample_y     <= 16'h0000;
      r_sample_z     <= 16'h0000;
      r_sample_valid <= 1'b0;
      r_configured   <= 1'b0;
      r_overrun      <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_poll_cnt     <= '0;
      r_to_cnt       <= '0;
      r_pending      <= 1'b0;
      r_int1_meta    <= 1'b0;
      r_int1_sync    <= 1'b0;
      r_int1_prev    <= 1'b0;
    end else begin
      r_spi_enable  <= w_en_next;
      r_spi_rw      <= w_rw_next;
      r_spi_address <= w_addr_next;
      r_spi_wdata   <= w_wdata_next;
      r_int1_meta   <= int1;
      r_int1_sync   <= r_int1_meta;
      r_int1_prev   <= r_int1_sync;
      r_poll_cnt    <= w_tick ? '0 : r_poll_cnt + PW'(1);
      // Counts cycles of a continuously requested transaction; restarts on any new request.
      r_to_cnt      <= (w_en_next && r_spi_enable && (w_next == r_state)) ? r_to_cnt + TW'(1) : '0;
      r_pending     <= (r_state == ST_WAIT) ? 1'b0 : (r_pending || w_trig);
      r_sample_valid <= w_accept;
      if (w_accept) begin
        r_sample_x <= {spi_rdata[39:32], spi_rdata[47:40]};
        r_sample_y <= {spi_rdata[23:16], spi_rdata[31:24]};
        r_sample_z <= {spi_rdata[7:0],   spi_rdata[15:8]};
      end
      if (w_accept && spi_rdata[55]) r_overrun <= 1'b1;
      else if (overrun_clr)          r_overrun <= 1'b0;
      if (w_timeout)                             r_configured <= 1'b0;
      else if (w_done && (r_state == ST_CFG2))   r_configured <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign spi_enable   = r_spi_enable;
  assign spi_rw       = r_spi_rw;
  assign spi_address  = r_spi_address;
  assign spi_wdata    = r_spi_wdata;
  assign sample_x     = r_sample_x;
  assign sample_y     = r_sample_y;
  assign sample_z     = r_sample_z;
  assign sample_valid = r_sample_valid;
  assign configured   = r_configured;
  assign overrun      = r_overrun;
  assign err_timeout  = r_err_timeout;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_accel_sequencer.sv
// Bench for accel_sequencer: SPI slave model, transaction/sample scoreboard fed by directed
// stimulus, and explicit checks of flags, poll cadence, trigger merging and timeout recovery.
module tb_accel_sequencer;

  localparam int RESP_DLY = 10;

  logic        sys_clock = 1'b0;
  logic        reset_n;
  logic        int1;
  logic        spi_ready;
  logic [55:0] spi_rdata;
  logic        overrun_clr;
  logic        spi_enable;
  logic        spi_rw;
  logic [5:0]  spi_address;
  logic [7:0]  spi_wdata;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        sample_valid;
  logic        configured;
  logic        overrun;
  logic        err_timeout;
  logic [2:0]  dbg_state;

  logic [14:0] exp_q[$];
  logic [47:0] samp_q[$];
  logic [55:0] rd_q[$];
  logic        clr_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  int   n_rd_starts = 0;
  int   last_rd_start = 0;
  int   cyc = 0;
  logic force_clr = 1'b0;
  logic respond_en = 1'b1;
  logic rd_en_prev = 1'b0;

  accel_sequencer #(
    .POLL_DIV(64),
    .CTRL_REG1_VAL(8'h2F),
    .CTRL_REG4_VAL(8'h00),
    .TIMEOUT_CYC(32),
    .USE_INT(1'b1)
  ) dut (
    .sys_clock(sys_clock),
    .reset_n(reset_n),
    .int1(int1),
    .spi_ready(spi_ready),
    .spi_rdata(spi_rdata),
    .overrun_clr(overrun_clr),
    .spi_enable(spi_enable),
    .spi_rw(spi_rw),
    .spi_address(spi_address),
    .spi_wdata(spi_wdata),
    .sample_x(sample_x),
    .sample_y(sample_y),
    .sample_z(sample_z),
    .sample_valid(sample_valid),
    .configured(configured),
    .overrun(overrun),
    .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // Clock / cycle index (cyc equals the number of the most recent rising edge)
  always #5 sys_clock = ~sys_clock;
  always @(posedge sys_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge sys_clock); #1;
    end
  endtask

  task automatic wait_txn(input int tgt);
    int k;
    k = 0;
    while (n_txn < tgt && k < 400) begin
      @(posedge sys_clock); #1;
      k++;
    end
    check("txn_wait", 64'(n_txn >= tgt), 64'(1));
  endtask

  task automatic wait_rd_start(input int base);
    int k;
    k = 0;
    while (n_rd_starts <= base && k < 200) begin
      @(posedge sys_clock); #1;
      k++;
    end
    check("rd_start_wait", 64'(n_rd_starts > base), 64'(1));
  endtask

  task automatic do_read(input logic [55:0] rd, input logic has_samp, input logic [47:0] xyz,
                         input logic clr);
    int tgt;
    tgt = n_txn + 1;
    rd_q.push_back(rd);
    clr_q.push_back(clr);
    exp_q.push_back({1'b1, 6'h27, 8'h00});
    if (has_samp) samp_q.push_back(xyz);
    wait_txn(tgt);
  endtask

  // SPI slave model: ready RESP_DLY cycles after enable is seen, read data from rd_q
  initial begin
    int mcnt;
    mcnt = 0;
    spi_ready = 1'b0;
    spi_rdata = '0;
    overrun_clr = 1'b0;
    forever begin
      @(posedge sys_clock); #2;
      spi_ready = 1'b0;
      overrun_clr = force_clr;
      if (!reset_n || !spi_enable || !respond_en) begin
        mcnt = 0;
      end else if (mcnt == RESP_DLY - 1) begin
        mcnt = 0;
        spi_ready = 1'b1;
        spi_rdata = '0;
        if (spi_rw && rd_q.size() > 0) begin
          spi_rdata = rd_q.pop_front();
          if (clr_q.pop_front()) overrun_clr = 1'b1;
        end
      end else begin
        mcnt++;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge sys_clock) begin
    if (spi_enable && spi_ready) begin
      n_txn++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL txn_unexpected: got rw=%0b addr=%0h wdata=%0h, required none", spi_rw,
                 spi_address, spi_wdata);
      end else begin
        check("txn", 64'({spi_rw, spi_address, spi_wdata}), 64'(exp_q.pop_front()));
      end
    end
    if (sample_valid) begin
      if (samp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sample_unexpected: got %h_%h_%h, required none", sample_x, sample_y,
                 sample_z);
      end else begin
        check("sample_xyz", 64'({sample_x, sample_y, sample_z}), 64'(samp_q.pop_front()));
      end
    end
    if (spi_enable && spi_rw && !rd_en_prev) begin
      n_rd_starts++;
      last_rd_start = cyc;
    end
    rd_en_prev = spi_enable && spi_rw;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before cycle 20000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int s;
    int base;
    int k;
    reset_n = 1'b0;
    int1 = 1'b0;
    force_clr = 1'b0;
    respond_en = 1'b1;
    repeat (3) @(posedge sys_clock);
    #1;
    check("rst_enable", 64'(spi_enable), 64'(0));
    check("rst_address", 64'(spi_address), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_flags", 64'({configured, overrun, err_timeout, sample_valid}), 64'(0));
    check("rst_samples", 64'({sample_x, sample_y, sample_z}), 64'(0));

    // Configuration writes after reset release
    exp_q.push_back({1'b0, 6'h20, 8'h2F});
    exp_q.push_back({1'b0, 6'h23, 8'h00});
    reset_n = 1'b1;
    @(posedge sys_clock); #1;
    check("cfg1_state", 64'(dbg_state), 64'(1));
    check("cfg1_req", 64'({spi_enable, spi_rw, spi_address, spi_wdata}), 64'({1'b1, 1'b0, 6'h20, 8'h2F}));
    wait_txn(1);
    check("cfg2_state", 64'(dbg_state), 64'(2));
    check("cfg_mid_configured", 64'(configured), 64'(0));
    wait_txn(2);
    check("configured", 64'(configured), 64'(1));
    check("wait_state", 64'(dbg_state), 64'(3));
    check("wait_enable", 64'(spi_enable), 64'(0));

    // Timer reads, sample unpacking, invalid status, overrun
    do_read(56'h08_34_12_00_80_FF_7F, 1'b1, 48'h1234_8000_7FFF, 1'b0);
    s = last_rd_start;
    do_read(56'h00_11_22_33_44_55_66, 1'b0, 48'h0, 1'b0);
    check("poll_interval_1", 64'(last_rd_start - s), 64'(64));
    check("samples_held", 64'({sample_x, sample_y, sample_z}), 64'(48'h1234_8000_7FFF));
    check("no_overrun", 64'(overrun), 64'(0));
    s = last_rd_start;
    do_read(56'h88_CD_AB_01_EF_02_10, 1'b1, 48'hABCD_EF01_1002, 1'b0);
    check("poll_interval_2", 64'(last_rd_start - s), 64'(64));
    check("overrun_set", 64'(overrun), 64'(1));
    force_clr = 1'b1;
    @(posedge sys_clock); #1;
    force_clr = 1'b0;
    @(posedge sys_clock); #1;
    check("overrun_cleared", 64'(overrun), 64'(0));
    do_read(56'h88_78_56_BC_9A_F0_DE, 1'b1, 48'h5678_9ABC_DEF0, 1'b1);
    check("overrun_set_wins", 64'(overrun), 64'(1));
    e = last_rd_start;

    // INT1-triggered read, then INT1 rise and timer expiry together during that read
    rd_q.push_back(56'h08_02_01_04_03_06_05);
    clr_q.push_back(1'b0);
    exp_q.push_back({1'b1, 6'h27, 8'h00});
    samp_q.push_back(48'h0102_0304_0506);
    rd_q.push_back(56'h08_20_10_40_30_60_50);
    clr_q.push_back(1'b0);
    exp_q.push_back({1'b1, 6'h27, 8'h00});
    samp_q.push_back(48'h1020_3040_5060);
    base = n_rd_starts;
    wait_until(e + 53);
    int1 = 1'b1;
    wait_until(e + 55);
    int1 = 1'b0;
    wait_until(e + 57);
    check("int1_read_start", 64'(last_rd_start - e), 64'(56));
    wait_until(e + 61);
    int1 = 1'b1;
    wait_until(e + 120);
    int1 = 1'b0;
    check("merged_read_count", 64'(n_rd_starts - base), 64'(2));
    check("followup_start", 64'(last_rd_start - e), 64'(67));
    check("queue_drained", 64'(exp_q.size() + samp_q.size()), 64'(0));

    // SPI never responds: timeout, then reconfiguration
    respond_en = 1'b0;
    wait_rd_start(n_rd_starts);
    s = last_rd_start;
    check("timer_after_merge", 64'(s - e), 64'(128));
    wait_until(s + 31);
    check("to_enable_held", 64'(spi_enable), 64'(1));
    check("to_err_before", 64'(err_timeout), 64'(0));
    wait_until(s + 32);
    check("to_enable_drop", 64'(spi_enable), 64'(0));
    check("to_err", 64'(err_timeout), 64'(1));
    check("to_configured", 64'(configured), 64'(0));
    check("to_state", 64'(dbg_state), 64'(1));
    exp_q.push_back({1'b0, 6'h20, 8'h2F});
    exp_q.push_back({1'b0, 6'h23, 8'h00});
    respond_en = 1'b1;
    k = 0;
    while (!configured && k < 200) begin
      @(posedge sys_clock); #1;
      k++;
    end
    check("reconfigured", 64'(configured), 64'(1));
    check("err_sticky", 64'(err_timeout), 64'(1));

    // Reset asserted in the middle of a read
    respond_en = 1'b0;
    wait_rd_start(n_rd_starts);
    check("read_after_reconfig", 64'(last_rd_start - s), 64'(64));
    repeat (3) @(posedge sys_clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_req", 64'({spi_enable, spi_rw, spi_address, spi_wdata}), 64'(0));
    check("midrst_samples", 64'({sample_x, sample_y, sample_z}), 64'(0));
    check("midrst_flags", 64'({configured, overrun, err_timeout, sample_valid}), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    repeat (3) @(posedge sys_clock);
    #1;
    check("final_queues", 64'(exp_q.size() + samp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
